// File: rtl/effects_pkg.sv
// Shared definitions for the effects chain: mode encodings, gate states and the
// clamp helper used for both full-scale saturation and hard clipping.
package effects_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_GAIN   = 2'd1;
    localparam logic [1:0] MODE_CLIP   = 2'd2;
    localparam logic [1:0] MODE_GATE   = 2'd3;

    // Unity gain for the default 12 fractional gain bits.
    localparam int UNITY_GAIN = 4096;

    typedef enum logic [1:0] {
        GATE_CLOSED = 2'd0,
        GATE_OPEN   = 2'd1,
        GATE_HOLD   = 2'd2
    } gate_state_t;

    function automatic logic signed [63:0] clamp(
        input logic signed [63:0] v,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        logic signed [63:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/effects_chain_noise_gate.sv
// Noise gate FSM (CLOSED/OPEN/HOLD); judges the sample entering the output stage
// and steps only when that stage actually loads a valid sample.
module noise_gate
    import effects_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int HOLD_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance_i,
    input  logic                       valid_i,
    input  logic                       enable_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic        [SAMPLE_W-2:0] thresh_i,
    input  logic        [HOLD_W-1:0]   hold_i,
    output logic                       pass_o
);

    gate_state_t         state_q, state_d, eval_state;
    logic [HOLD_W-1:0]   cnt_q, cnt_d, eval_cnt;
    logic [SAMPLE_W-1:0] mag;
    logic                loud;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GATE_CLOSED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // Unsigned magnitude keeps 2^(SAMPLE_W-1) representable for the most-negative input.
        mag        = sample_i[SAMPLE_W-1] ? $unsigned(-sample_i) : $unsigned(sample_i);
        loud       = mag >= {1'b0, thresh_i};
        eval_state = state_q;
        eval_cnt   = cnt_q;
        if (!enable_i) begin
            eval_state = GATE_CLOSED;
            eval_cnt   = '0;
        end else begin
            case (state_q)
                GATE_CLOSED: begin
                    if (loud) eval_state = GATE_OPEN;
                end
                GATE_OPEN: begin
                    if (!loud) begin
                        eval_state = GATE_HOLD;
                        eval_cnt   = hold_i;
                    end
                end
                GATE_HOLD: begin
                    if (loud) begin
                        eval_state = GATE_OPEN;
                    end else if (cnt_q == '0) begin
                        eval_state = GATE_CLOSED;
                    end else begin
                        eval_cnt = cnt_q - HOLD_W'(1);
                    end
                end
                default: begin
                    eval_state = GATE_CLOSED;
                    eval_cnt   = '0;
                end
            endcase
        end
        state_d = (advance_i && valid_i) ? eval_state : state_q;
        cnt_d   = (advance_i && valid_i) ? eval_cnt   : cnt_q;
    end

    // A sample passes whenever the state it lands in is not CLOSED.
    always_comb begin
        pass_o = !enable_i || (eval_state != GATE_CLOSED);
    end

endmodule

// File: rtl/effects_chain.sv
// Four-stage audio effects pipeline: capture, multiply, scale/saturate/clip, gate.
// All stages stall together when the output is full and not being accepted.
module effects_chain
    import effects_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int GAIN_W    = 16,
    parameter int FRAC_BITS = 12,
    parameter int HOLD_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    input  logic        [GAIN_W-1:0]   gain,
    input  logic        [SAMPLE_W-2:0] clip_level,
    input  logic        [SAMPLE_W-2:0] gate_thresh,
    input  logic        [HOLD_W-1:0]   gate_hold,
    input  logic        [1:0]          mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_sample
);

    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_LO = -(64'sd1 <<< (SAMPLE_W - 1));

    logic                       advance;
    logic                       gate_pass;

    logic                       s0_valid_q;
    logic signed [SAMPLE_W-1:0] s0_sample_q;
    logic        [GAIN_W-1:0]   s0_gain_q;
    logic        [SAMPLE_W-2:0] s0_clip_q, s0_thresh_q;
    logic        [HOLD_W-1:0]   s0_hold_q;
    logic        [1:0]          s0_mode_q;

    logic                       s1_valid_q;
    logic signed [PROD_W-1:0]   s1_prod_q, s1_prod_d;
    logic signed [SAMPLE_W-1:0] s1_sample_q;
    logic        [SAMPLE_W-2:0] s1_clip_q, s1_thresh_q;
    logic        [HOLD_W-1:0]   s1_hold_q;
    logic        [1:0]          s1_mode_q;

    logic                       s2_valid_q;
    logic signed [SAMPLE_W-1:0] s2_x_q, s2_x_d;
    logic        [SAMPLE_W-2:0] s2_thresh_q;
    logic        [HOLD_W-1:0]   s2_hold_q;
    logic        [1:0]          s2_mode_q;

    logic                       out_valid_q;
    logic signed [SAMPLE_W-1:0] out_sample_q;

    logic signed [PROD_W-1:0]   shifted;
    logic signed [63:0]         scaled, saturated, clipped, clip_mag;

    assign advance  = out_ready || !out_valid_q;
    assign in_ready = rst || advance;

    always_comb begin
        s1_prod_d = PROD_W'(s0_sample_q) * PROD_W'($signed({1'b0, s0_gain_q}));
    end

    always_comb begin
        shifted   = s1_prod_q >>> FRAC_BITS;
        scaled    = 64'(shifted);
        saturated = clamp(scaled, SAT_LO, SAT_HI);
        clip_mag  = 64'(s1_clip_q);
        clipped   = (s1_mode_q >= MODE_CLIP) ? clamp(saturated, -clip_mag, clip_mag) : saturated;
        s2_x_d    = (s1_mode_q == MODE_BYPASS) ? s1_sample_q : SAMPLE_W'(clipped);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q   <= 1'b0;
            s0_sample_q  <= '0;
            s0_gain_q    <= GAIN_W'(UNITY_GAIN);
            s0_clip_q    <= '0;
            s0_thresh_q  <= '0;
            s0_hold_q    <= '0;
            s0_mode_q    <= MODE_BYPASS;
            s1_valid_q   <= 1'b0;
            s1_prod_q    <= '0;
            s1_sample_q  <= '0;
            s1_clip_q    <= '0;
            s1_thresh_q  <= '0;
            s1_hold_q    <= '0;
            s1_mode_q    <= MODE_BYPASS;
            s2_valid_q   <= 1'b0;
            s2_x_q       <= '0;
            s2_thresh_q  <= '0;
            s2_hold_q    <= '0;
            s2_mode_q    <= MODE_BYPASS;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
        end else if (advance) begin
            s0_valid_q   <= in_valid;
            s0_sample_q  <= in_sample;
            s0_gain_q    <= gain;
            s0_clip_q    <= clip_level;
            s0_thresh_q  <= gate_thresh;
            s0_hold_q    <= gate_hold;
            s0_mode_q    <= mode;
            s1_valid_q   <= s0_valid_q;
            s1_prod_q    <= s1_prod_d;
            s1_sample_q  <= s0_sample_q;
            s1_clip_q    <= s0_clip_q;
            s1_thresh_q  <= s0_thresh_q;
            s1_hold_q    <= s0_hold_q;
            s1_mode_q    <= s0_mode_q;
            s2_valid_q   <= s1_valid_q;
            s2_x_q       <= s2_x_d;
            s2_thresh_q  <= s1_thresh_q;
            s2_hold_q    <= s1_hold_q;
            s2_mode_q    <= s1_mode_q;
            out_valid_q  <= s2_valid_q;
            out_sample_q <= gate_pass ? s2_x_q : '0;
        end
    end

    noise_gate #(
        .SAMPLE_W (SAMPLE_W),
        .HOLD_W   (HOLD_W)
    ) u_gate (
        .clk       (clk),
        .rst       (rst),
        .advance_i (advance),
        .valid_i   (s2_valid_q),
        .enable_i  (s2_mode_q == MODE_GATE),
        .sample_i  (s2_x_q),
        .thresh_i  (s2_thresh_q),
        .hold_i    (s2_hold_q),
        .pass_o    (gate_pass)
    );

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;

endmodule

// File: tb/tb_effects_chain.sv
// Bench for effects_chain: directed spec vectors, stall/reset scenarios and random
// traffic scored against an arithmetic reference model of gain, clip and gate.
module tb_effects_chain;
    import effects_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_sample = '0;
    logic        [15:0] gain = '0;
    logic        [14:0] clip_level = '0;
    logic        [14:0] gate_thresh = '0;
    logic        [15:0] gate_hold = '0;
    logic        [1:0]  mode = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_sample;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_out    = 0;

    typedef struct {
        int v;
        int cyc;
        bit lat;
    } ent_t;
    ent_t exp_q[$];

    // Gate reference: open after a loud sample, then passes at most hold+1 quiet samples.
    bit seen_loud  = 1'b0;
    int quiet_run  = 0;

    effects_chain dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sample   (in_sample),
        .gain        (gain),
        .clip_level  (clip_level),
        .gate_thresh (gate_thresh),
        .gate_hold   (gate_hold),
        .mode        (mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sample  (out_sample)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_proc(input int s, input int g, input int c, input int m);
        longint p;
        longint q;
        if (m == 0) return s;
        p = longint'(s) * longint'(g);
        q = p / 4096;
        if (p < 0 && (p % 4096) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        if (m >= 2) begin
            if (q > c) q = c;
            if (q < -c) q = -c;
        end
        return int'(q);
    endfunction

    function automatic int model_gate(input int x, input int t, input int h, input int m);
        int mag;
        if (m != 3) begin
            seen_loud = 1'b0;
            quiet_run = 0;
            return x;
        end
        mag = (x < 0) ? -x : x;
        if (mag >= t) begin
            seen_loud = 1'b1;
            quiet_run = 0;
            return x;
        end
        quiet_run++;
        if (seen_loud && quiet_run <= h + 1) return x;
        seen_loud = 1'b0;
        return 0;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input int g, input int c, input int t, input int h, input int m,
                        input bit lit_en, input int lit, input bit lat);
        ent_t e;
        int   k;
        e.v = model_gate(model_proc(s, g, c, m), t, h, m);
        if (lit_en) e.v = lit;
        e.lat       = lat;
        in_sample   = 16'(s);
        gain        = 16'(g);
        clip_level  = 15'(c);
        gate_thresh = 15'(t);
        gate_hold   = 16'(h);
        mode        = 2'(m);
        in_valid    = 1'b1;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
        end
        if (k == 1000) chk("in_ready_timeout", in_ready, 1);
        e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic dsend(input int s, input int g, input int c, input int t, input int h, input int m,
                         input int lit);
        send(s, g, c, t, h, m, 1'b1, lit, 1'b1);
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 500; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                n_out++;
                $display("out %0d @cyc %0d: sample=%0d expected=%0d", n_out, cyc, out_sample, e.v);
                chk("out_sample", out_sample, e.v);
                if (e.lat) chk("latency", cyc, e.cyc + 4);
            end
        end
        if (!rst && out_valid === 1'b1 && !out_ready) chk("in_ready_stalled", in_ready, 0);
        if (out_valid === 1'b0) chk("in_ready_free", in_ready, 1);
    end

    initial begin
        bit [3:0] pat;
        bit       done;
        int       idx;
        int       n0;
        pat = 4'b1001;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sample", out_sample, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        sync();

        // Directed vectors, out_ready held high
        dsend(1000, UNITY_GAIN, 0, 0, 0, 1, 1000);
        dsend(-1000, UNITY_GAIN, 0, 0, 0, 1, -1000);
        dsend(20000, 8192, 16000, 0, 0, 2, 16000);
        dsend(-20000, 8192, 16000, 0, 0, 2, -16000);
        dsend(100, 8192, 16000, 0, 0, 2, 200);
        dsend(-32768, 65535, 0, 0, 0, 1, -32768);
        dsend(32767, 65535, 0, 0, 0, 1, 32767);
        dsend(-32768, 0, 0, 0, 0, 0, -32768);
        dsend(12345, 0, 0, 0, 0, 0, 12345);
        dsend(1234, UNITY_GAIN, 0, 0, 0, 2, 0);
        dsend(-3, 2048, 0, 0, 0, 1, -2);
        dsend(3, 2048, 0, 0, 0, 1, 1);
        // Gate, hold = 2
        dsend(500, UNITY_GAIN, 32767, 100, 2, 3, 500);
        dsend(10, UNITY_GAIN, 32767, 100, 2, 3, 10);
        dsend(10, UNITY_GAIN, 32767, 100, 2, 3, 10);
        dsend(10, UNITY_GAIN, 32767, 100, 2, 3, 10);
        dsend(10, UNITY_GAIN, 32767, 100, 2, 3, 0);
        dsend(10, UNITY_GAIN, 32767, 100, 2, 3, 0);
        dsend(200, UNITY_GAIN, 32767, 100, 2, 3, 200);
        dsend(5, UNITY_GAIN, 0, 0, 0, 1, 5);
        // Gate, hold = 0
        dsend(300, UNITY_GAIN, 32767, 100, 0, 3, 300);
        dsend(1, UNITY_GAIN, 32767, 100, 0, 3, 1);
        dsend(1, UNITY_GAIN, 32767, 100, 0, 3, 0);
        dsend(5, UNITY_GAIN, 0, 0, 0, 1, 5);
        // Full-scale magnitude against the largest threshold
        dsend(-32767, UNITY_GAIN, 32767, 32767, 0, 3, -32767);
        dsend(32766, UNITY_GAIN, 32767, 32767, 0, 3, 32766);
        dsend(5, UNITY_GAIN, 32767, 32767, 0, 3, 0);
        drain("directed_drain");

        // Backpressure with out_ready pattern 1-0-0-1
        sync();
        n0   = n_out;
        done = 1'b0;
        idx  = 0;
        fork
            begin
                for (int i = 1; i <= 10; i++) send(i, UNITY_GAIN, 0, 0, 0, 1, 1'b1, i, 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = pat[idx % 4];
                    idx++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain("stall_drain");
        chk("stall_count", n_out - n0, 10);

        // Random gain/clip/bypass traffic with random backpressure
        sync();
        done = 1'b0;
        fork
            begin
                int s, g, c, m;
                for (int i = 0; i < 150; i++) begin
                    s = int'($urandom_range(0, 65535)) - 32768;
                    g = int'($urandom_range(0, 65535));
                    c = int'($urandom_range(0, 32767));
                    m = int'($urandom_range(0, 2));
                    send(s, g, c, 0, 0, m, 1'b0, 0, 1'b0);
                    if ($urandom_range(0, 3) == 0) sync();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain("rand_drain");

        // Random gate traffic
        sync();
        done = 1'b0;
        fork
            begin
                int s, t, h, mg;
                t = int'($urandom_range(50, 2000));
                h = int'($urandom_range(0, 4));
                for (int i = 0; i < 120; i++) begin
                    if ($urandom_range(0, 2) == 0) mg = int'($urandom_range(t, 30000));
                    else mg = int'($urandom_range(0, t - 1));
                    s = ($urandom_range(0, 1) == 1) ? -mg : mg;
                    send(s, UNITY_GAIN, 32767, t, h, 3, 1'b0, 0, 1'b0);
                    if ($urandom_range(0, 4) == 0) sync();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain("gate_rand_drain");

        // Reset with three samples in flight, plus a simultaneous input offer
        sync();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(100 + i, UNITY_GAIN, 0, 0, 0, 1, 1'b0, 0, 1'b0);
        in_valid  = 1'b1;
        in_sample = 16'sd777;
        mode      = 2'd1;
        rst       = 1'b1;
        exp_q.delete();
        seen_loud = 1'b0;
        quiet_run = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("no_stale_out", out_valid, 0);
        end
        sync();
        dsend(42, UNITY_GAIN, 0, 0, 0, 1, 42);
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
